// File: rtl/lab4_net_bus_pkg.sv
// Shared definitions for the 4-port bus network packet scheduler.
//   c_nports    : number of bus ports (fixed at 4)
//   state_t     : scheduler FSM state (IDLE = arbitrate, LOCKED = wormhole held)
//   idx2onehot  : 2-bit port index to 4-bit one-hot vector
package lab4_net_bus_pkg;

   localparam int unsigned c_nports = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   function automatic logic [3:0] idx2onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/lab4_net_bus_rr_pick.sv
// Combinational rotating-priority picker.
//   reqs    : request vector, one bit per port
//   ptr     : highest-priority port index
//   gnt_val : high when any request is present
//   gnt_idx : first requesting port scanning ptr, ptr+1, ... mod 4
module lab4_net_bus_rr_pick
   import lab4_net_bus_pkg::*;
(
   input  logic [3:0] reqs,
   input  logic [1:0] ptr,
   output logic       gnt_val,
   output logic [1:0] gnt_idx
);

   logic [1:0] cand;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      gnt_val = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int unsigned k = 0; k < c_nports; k++) begin
         cand = ptr + 2'(c_nports - 1 - k);
         if (reqs[cand]) begin
            gnt_val = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/lab4_net_bus_pkt_sched.sv
// Packet-level (wormhole) scheduler for the 4-port bus network.
// A requester that wins with a non-tail flit keeps the bus until its tail
// transfers; round-robin priority advances only at packet boundaries.
//   clk, reset       : clock, synchronous active-high reset
//   inq_val/inq_rdy  : input-queue head valid / dequeue strobe per port
//   inq_dest0..3     : destination of each queue's head flit
//   inq_last         : tail-flit flag of each queue's head flit
//   out_val/out_rdy  : one-hot valid toward outputs / output-port ready
//   sel              : bus datapath mux select
//   busy, owner      : lock held / lock holder index
//   xfer_count       : number of flits transferred (wraps)
module lab4_net_bus_pkt_sched
   import lab4_net_bus_pkg::*;
#(
   parameter int unsigned p_cnt_nbits = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             inq_val,
   output logic [3:0]             inq_rdy,
   input  logic [1:0]             inq_dest0,
   input  logic [1:0]             inq_dest1,
   input  logic [1:0]             inq_dest2,
   input  logic [1:0]             inq_dest3,
   input  logic [3:0]             inq_last,
   output logic [3:0]             out_val,
   input  logic [3:0]             out_rdy,
   output logic [1:0]             sel,
   output logic                   busy,
   output logic [1:0]             owner,
   output logic [p_cnt_nbits-1:0] xfer_count
);

   state_t                 state_q, state_d;
   logic [1:0]             ptr_q, ptr_d;
   logic [1:0]             own_q, own_d;
   logic [1:0]             ldest_q, ldest_d;
   logic [p_cnt_nbits-1:0] cnt_q, cnt_d;

   logic [3:0][1:0] dest_all;
   logic            gnt_val;
   logic [1:0]      gnt_idx;
   logic [1:0]      gdest;
   logic            fire;

   assign dest_all = {inq_dest3, inq_dest2, inq_dest1, inq_dest0};
   assign gdest    = dest_all[gnt_idx];

   lab4_net_bus_rr_pick u_pick (
      .reqs    (inq_val),
      .ptr     (ptr_q),
      .gnt_val (gnt_val),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      ldest_d = ldest_q;
      cnt_d   = cnt_q;
      out_val = '0;
      inq_rdy = '0;
      sel     = '0;
      fire    = 1'b0;
      // Outputs stay forced to zero for the whole reset cycle.
      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (gnt_val) begin
                  sel              = gnt_idx;
                  out_val          = idx2onehot(gdest);
                  inq_rdy[gnt_idx] = out_rdy[gdest];
                  fire             = out_rdy[gdest];
                  if (fire) begin
                     if (inq_last[gnt_idx]) begin
                        ptr_d = gnt_idx + 2'd1;
                     end else begin
                        state_d = LOCKED;
                        own_d   = gnt_idx;
                        ldest_d = gdest;
                     end
                  end
               end
            end
            LOCKED: begin
               sel = own_q;
               // Owner bubble drives nothing; other ports stay masked.
               if (inq_val[own_q]) begin
                  out_val        = idx2onehot(ldest_q);
                  inq_rdy[own_q] = out_rdy[ldest_q];
                  fire           = out_rdy[ldest_q];
                  if (fire && inq_last[own_q]) begin
                     state_d = IDLE;
                     ptr_d   = own_q + 2'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         if (fire) begin
            cnt_d = cnt_q + p_cnt_nbits'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         ldest_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         ldest_q <= ldest_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy       = !reset && (state_q == LOCKED);
   assign owner      = reset ? 2'b00 : own_q;
   assign xfer_count = reset ? '0 : cnt_q;

endmodule

// File: doc/lab4_net_bus_pkt_sched.md
# lab4_net_bus_pkt_sched

Packet-level scheduler for the 4-port bus network. It replaces per-message re-arbitration with a wormhole lock. Once a requester wins the bus with a non-tail flit, it keeps the bus until its tail flit transfers, and round-robin priority advances only at packet boundaries. It drives the bus datapath's mux select and the per-port val/rdy handshakes, and it exports ownership and a transfer counter for debug and performance runs.

## Interface
- c_nports, 4, number of bus ports; fixed, other values are unsupported
- p_cnt_nbits, 16, width of the flit transfer counter
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  reset, synchronous, active-high
- inq_val  input  4  input-queue head valid, one bit per port
- inq_rdy  output  4  dequeue strobe back to each input queue
- inq_dest0..inq_dest3  input  2 each  destination field of each queue's head flit
- inq_last  input  4  tail-flit flag of each queue's head flit
- out_val  output  4  one-hot valid toward the output ports
- out_rdy  input  4  output-port ready
- sel  output  2  bus datapath mux select (winning input index)
- busy  output  1  high while a multi-flit packet holds the lock
- owner  output  2  index of the lock holder
- xfer_count  output  p_cnt_nbits  count of flits transferred

## Operation
- A transfer fires for port i when inq_val[i] && inq_rdy[i].
- State registers:
  - state: IDLE or LOCKED.
  - ptr (2b): highest-priority port.
  - own (2b): lock holder.
  - ldest (2b): locked destination.
  - cnt: flit counter.
- IDLE:
  - Pick g = first port with inq_val set, scanning ptr, ptr+1, … mod 4.
  - Outputs: sel = g; out_val = onehot(inq_dest_g); inq_rdy[g] = out_rdy[inq_dest_g]; all other inq_rdy bits 0.
  - No valid requester: out_val = 0, inq_rdy = 0, sel = 0, no state change.
  - Fire with inq_last[g] = 1 (single-flit packet): stay IDLE, ptr <= g+1.
  - Fire with inq_last[g] = 0: state <= LOCKED, own <= g, ldest <= inq_dest_g. ptr is unchanged.
  - No fire: nothing is committed. The grant may move next cycle and ptr is unchanged.
- LOCKED:
  - Outputs: sel = own; out_val = inq_val[own] ? onehot(ldest) : 0; inq_rdy[own] = out_rdy[ldest]; all other inq_rdy bits 0.
  - inq_dest_own is ignored for body and tail flits; ldest is authoritative.
  - Other requesters are fully masked, whatever their val.
  - Fire with inq_last[own] = 1: state <= IDLE, ptr <= own+1.
  - Owner bubble (inq_val[own] = 0): hold LOCKED, drive nothing.
- busy = (state == LOCKED). owner = own.
- cnt increments by 1 on every fire, in either state, and wraps modulo 2^p_cnt_nbits. xfer_count = cnt.
- At most one inq_rdy bit and at most one out_val bit are high in any cycle.

## Timing
- Arbitration and handshake are combinational: inq_val/inq_dest/out_rdy to inq_rdy/out_val/sel has zero-cycle latency.
- Ownership, ptr and cnt update on the clock edge after the firing cycle.
- First flit of a packet transfers in the cycle it wins. Each subsequent flit transfers in any cycle where owner val and out_rdy[ldest] are both high; the full rate is 1 flit/cycle.
- Reset (synchronous, applies whenever reset = 1, including mid-packet):
  - state <= IDLE, ptr <= 0, own <= 0, ldest <= 0, cnt <= 0.
  - A held lock is abandoned.
- While reset = 1, outputs are forced: out_val = 0, inq_rdy = 0, sel = 0, busy = 0, owner = 0, xfer_count = 0.
- Simultaneous tail fire and new request in the same cycle: the new request is not arbitrated until the next cycle, which is IDLE arbitration using the updated ptr.

## Structure
- Package lab4_net_bus_pkg holds:
  - c_nports = 4.
  - State enum {IDLE, LOCKED}.
  - Function for 2-bit index to 4-bit one-hot.
- Sub-module lab4_net_bus_rr_pick: combinational rotating-priority picker.
  - Inputs: reqs[3:0], ptr[1:0].
  - Outputs: gnt_val, gnt_idx[1:0].
- Top level holds the FSM, the registers and the handshake steering.

## Test plan
- After reset: all inq_val = 4'b1111 with out_rdy = 0 -> out_val = 0, inq_rdy = 0. Then set out_rdy = 4'b1111 with every head inq_last = 1 -> winners in order 0, 1, 2, 3, 0 over 5 cycles; xfer_count = 5.
- Port 2 sends a 3-flit packet to dest 1 (last = 0, 0, 1) while port 0 holds val the whole time -> sel = 2 for 3 fires, inq_rdy[0] = 0 throughout, busy = 1 for 2 cycles. Port 0 wins the cycle after the tail fires.
- Locked port 1 to dest 3; the body flit's inq_dest1 changes to 0 -> out_val stays 4'b1000.
- Locked port 3: out_rdy[ldest] = 0 for 4 cycles, then inq_val[3] = 0 for 2 cycles -> no fires, busy stays 1, no other port granted. The tail then completes normally.
- Reset asserted mid-packet (busy = 1, cnt = 7) -> next cycle busy = 0, xfer_count = 0, ptr = 0 (port 0 wins the next contention).
- p_cnt_nbits = 4 with 17 single-flit fires -> xfer_count = 1 (wrap).
